// File: rtl/dma_pkg.sv
//==============================================================================
// Module   : dma_pkg
// Brief    : Shared DMA engine definitions: staging-buffer word width, depth
//            and the word type used between the ICB read and write phases.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package dma_pkg;

    // Word width of the DMA data path (matches the core XLEN).
    localparam int DMA_DATA_WIDTH = 32;

    // One DMA burst is 16 words; the staging FIFO holds exactly one burst.
    localparam int DMA_FIFO_DEPTH = 16;

    typedef logic [DMA_DATA_WIDTH-1:0] dma_word_t;

endpackage : dma_pkg

`default_nettype wire

// File: rtl/dma_fifo_ram.sv
//==============================================================================
// Module   : dma_fifo_ram
// Brief    : DEPTH x DATA_WIDTH storage array for the DMA staging FIFO.
//            Synchronous write port, asynchronous read port, no reset
//            (contents are only ever observed through valid FIFO entries).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dma_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the pushed word at the write pointer.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port is combinational so the head word is visible without latency.
    assign rdata_o = mem_q[raddr_i];

endmodule : dma_fifo_ram

`default_nettype wire

// File: rtl/dma_fifo.sv
//==============================================================================
// Module   : dma_fifo
// Brief    : Single-clock show-ahead (first-word-fall-through) FIFO used as
//            the DMA staging buffer. Read responses are pushed; every accepted
//            write command pops one word. The head word is always presented
//            on out_data (0 when empty) so it can drive write data directly.
// Config   : define DMA_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow
//            outputs; without it ignored push/pop requests are silent.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dma_fifo
    import dma_pkg::*;
#(
    parameter  int DATA_WIDTH = DMA_DATA_WIDTH,
    parameter  int DEPTH      = DMA_FIFO_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buffer_write_en,
    input  logic                  buffer_read_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  empty,
    output logic                  full,
`ifdef DMA_FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0]   c_LEVEL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_LEVEL_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q,  level_d;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_push;
    logic                  w_pop;

    // Status flags come only from the registered level, never from the enables.
    assign empty = (level_q == '0);
    assign full  = (level_q == c_LEVEL_FULL);
    assign level = level_q;

    // A push into a full FIFO is still accepted when a pop frees a slot in the
    // same cycle; a pop is only accepted when there is a word to consume.
    assign w_push = buffer_write_en & (~full | buffer_read_en);
    assign w_pop  = buffer_read_en & ~empty;

    dma_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_head)
    );

    // Mask the head with empty so stale storage never leaks onto out_data.
    assign out_data = empty ? '0 : w_head;

    // Next-state for pointers and occupancy; pointers wrap naturally mod DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + c_LEVEL_ONE;
            2'b01:   level_d = level_q - c_LEVEL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer/occupancy registers; reset discards every held entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef DMA_FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set on any dropped request, cleared only by reset.
    always_comb begin
        overflow_d  = overflow_q  | (buffer_write_en & ~w_push);
        underflow_d = underflow_q | (buffer_read_en  & ~w_pop);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule : dma_fifo

`default_nettype wire

// File: tb/tb_dma_fifo.sv
//==============================================================================
// Module   : tb_dma_fifo
// Brief    : Self-checking bench for dma_fifo. A queue-based reference model
//            tracks contents, occupancy and sticky error flags; directed
//            scenarios are followed by a randomized push/pop/reset phase.
// Config   : honours DMA_FIFO_ERR_FLAGS_EN to check overflow/underflow.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dma_fifo;
    import dma_pkg::*;

    localparam int DEPTH = DMA_FIFO_DEPTH;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      buffer_write_en = 1'b0;
    logic      buffer_read_en  = 1'b0;
    dma_word_t in_data = '0;
    dma_word_t out_data;
    logic      empty;
    logic      full;
    logic [4:0] level;
`ifdef DMA_FIFO_ERR_FLAGS_EN
    logic      overflow;
    logic      underflow;
`endif

    dma_fifo dut (
        .clk             (clk),
        .rst             (rst),
        .buffer_write_en (buffer_write_en),
        .buffer_read_en  (buffer_read_en),
        .in_data         (in_data),
        .out_data        (out_data),
        .empty           (empty),
        .full            (full),
`ifdef DMA_FIFO_ERR_FLAGS_EN
        .overflow        (overflow),
        .underflow       (underflow),
`endif
        .level           (level)
    );

    always #5 clk = ~clk;

    // Reference model state.
    dma_word_t model_q[$];
    bit        m_ovf;
    bit        m_udf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all(input string tag);
        dma_word_t exp_head;
        exp_head = (model_q.size() == 0) ? '0 : model_q[0];
        check({tag, "_level"}, 64'(level), 64'(model_q.size()));
        check({tag, "_empty"}, 64'(empty), 64'(model_q.size() == 0));
        check({tag, "_full"},  64'(full),  64'(model_q.size() == DEPTH));
        check({tag, "_data"},  64'(out_data), 64'(exp_head));
`ifdef DMA_FIFO_ERR_FLAGS_EN
        check({tag, "_ovf"},   64'(overflow),  64'(m_ovf));
        check({tag, "_udf"},   64'(underflow), 64'(m_udf));
`endif
    endtask

    // One clock with the given request; the model advances at the same edge.
    task automatic cycle(input bit we, input bit re, input dma_word_t d, input string tag);
        bit push_ok, pop_ok;
        buffer_write_en = we;
        buffer_read_en  = re;
        in_data         = d;
        @(posedge clk);
        pop_ok  = re && (model_q.size() > 0);
        push_ok = we && ((model_q.size() < DEPTH) || re);
        if (we && !push_ok) m_ovf = 1'b1;
        if (re && !pop_ok)  m_udf = 1'b1;
        if (pop_ok)  void'(model_q.pop_front());
        if (push_ok) model_q.push_back(d);
        #1;
        buffer_write_en = 1'b0;
        buffer_read_en  = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input int n, input bit we, input bit re, input string tag);
        rst = 1'b1;
        buffer_write_en = we;
        buffer_read_en  = re;
        in_data = 32'hBAD0_BAD0;
        repeat (n) @(posedge clk);
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        rst = 1'b0;
        buffer_write_en = 1'b0;
        buffer_read_en  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        dma_word_t d;
        // 1. Reset for two cycles.
        do_reset(2, 1'b0, 1'b0, "t1_reset");
        check("t1_out_zero", 64'(out_data), 64'h0);

        // 2. Two pushes, show-ahead head after the first edge.
        cycle(1'b1, 1'b0, 32'h1111_1111, "t2_push1");
        check("t2_head", 64'(out_data), 64'h1111_1111);
        check("t2_not_empty", 64'(empty), 64'h0);
        cycle(1'b1, 1'b0, 32'h2222_2222, "t2_push2");
        check("t2_level2", 64'(level), 64'd2);
        do_reset(1, 1'b0, 1'b0, "t2_clear");

        // 3. Fill, drop 17th, drain in order.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, dma_word_t'(i), "t3_fill");
        check("t3_full", 64'(full), 64'h1);
        check("t3_level16", 64'(level), 64'd16);
        cycle(1'b1, 1'b0, 32'h0000_DEAD, "t3_drop");
        check("t3_level_after_drop", 64'(level), 64'd16);
`ifdef DMA_FIFO_ERR_FLAGS_EN
        check("t3_overflow", 64'(overflow), 64'h1);
`endif
        for (int i = 0; i < 16; i++) begin
            check("t3_drain_head", 64'(out_data), 64'(i));
            cycle(1'b0, 1'b1, '0, "t3_drain");
        end
        check("t3_empty", 64'(empty), 64'h1);
        do_reset(1, 1'b0, 1'b0, "t3_clear");

        // 4. Full + push + pop.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'h100 + dma_word_t'(i), "t4_fill");
        cycle(1'b1, 1'b1, 32'h0000_00AA, "t4_pushpop");
        check("t4_level16", 64'(level), 64'd16);
        check("t4_head_adv", 64'(out_data), 64'h101);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, '0, "t4_drain");
        check("t4_last_aa", 64'(out_data), 64'hAA);
        cycle(1'b0, 1'b1, '0, "t4_drain_last");
        do_reset(1, 1'b0, 1'b0, "t4_clear");

        // 5. Pop while empty, then push+pop while empty.
        cycle(1'b0, 1'b1, '0, "t5_pop_empty");
        check("t5_level0", 64'(level), 64'd0);
`ifdef DMA_FIFO_ERR_FLAGS_EN
        check("t5_underflow", 64'(underflow), 64'h1);
`endif
        cycle(1'b1, 1'b1, 32'h5555_5555, "t5_pushpop_empty");
        check("t5_level1", 64'(level), 64'd1);
        check("t5_head", 64'(out_data), 64'h5555_5555);
        do_reset(1, 1'b1, 1'b1, "t5_reset_prio");

        // 6. Wrap-around: fill 10 / drain 10 three times.
        d = 32'h1000;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                cycle(1'b1, 1'b0, d, "t6_fill");
                d = d + 1;
            end
            for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0, "t6_drain");
        end
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h2000 + dma_word_t'(i), "t6_hold5");
        check("t6_level5", 64'(level), 64'd5);
        do_reset(1, 1'b0, 1'b0, "t6_reset");
        check("t6_empty_after_rst", 64'(empty), 64'h1);

        // Randomized phase with varying push/pop bias and occasional reset.
        for (int blk = 0; blk < 8; blk++) begin
            int wp, rp;
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    do_reset(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "rnd_reset");
                end else begin
                    cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                          dma_word_t'($urandom), "rnd");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dma_fifo

`default_nettype wire
